// File: rtl/controle_varredura_servo.sv
// controle_varredura_servo
// Steps the 3-bit servo position code back and forth (0..7..0), holds each
// position for a dwell time, then requests one measurement and waits for it
// to finish or time out before moving to the next position.
module controle_varredura_servo #(
  parameter int TEMPO_ESPERA  = 100_000_000,
  parameter int TEMPO_TIMEOUT = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto,
  output logic [2:0] posicao,
  output logic       medir,
  output logic       erro_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    ESPERA  = 4'h1,
    MEDIR   = 4'h2,
    AGUARDA = 4'h3,
    AVANCA  = 4'h4,
    PARADO  = 4'h5
  } estado_t;

  localparam logic [31:0] FIM_ESPERA  = 32'(TEMPO_ESPERA - 1);
  localparam logic [31:0] FIM_TIMEOUT = 32'(TEMPO_TIMEOUT - 1);

  estado_t     estado;
  logic [31:0] contagem;
  logic        descendo;

  // Moore outputs decoded straight from the state register, so they follow
  // the asynchronous reset without waiting for a clock edge
  assign medir     = (estado == MEDIR);
  assign db_estado = estado;

  // Sweep FSM: state, shared dwell/timeout counter, position, direction and
  // the sticky timeout flag all live in this one register block
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      contagem     <= '0;
      posicao      <= 3'd0;
      descendo     <= 1'b0;
      erro_timeout <= 1'b0;
    end else begin
      case (estado)
        INICIAL: begin
          contagem <= '0;
          if (ligar) estado <= ESPERA;
        end

        ESPERA: begin
          if (!ligar) begin
            estado   <= PARADO;
            contagem <= '0;
          end else if (contagem == FIM_ESPERA) begin
            estado   <= MEDIR;
            contagem <= '0;
          end else begin
            contagem <= contagem + 32'd1;
          end
        end

        MEDIR: begin
          estado   <= AGUARDA;
          contagem <= '0;
        end

        AGUARDA: begin
          if (pronto) begin
            estado       <= AVANCA;
            contagem     <= '0;
            erro_timeout <= 1'b0;
          end else if (contagem == FIM_TIMEOUT) begin
            estado       <= AVANCA;
            contagem     <= '0;
            erro_timeout <= 1'b1;
          end else begin
            contagem <= contagem + 32'd1;
          end
        end

        AVANCA: begin
          contagem <= '0;
          estado   <= ligar ? ESPERA : PARADO;
          if (!descendo) begin
            if (posicao == 3'd7) begin
              posicao  <= 3'd6;
              descendo <= 1'b1;
            end else begin
              posicao <= posicao + 3'd1;
            end
          end else begin
            if (posicao == 3'd0) begin
              posicao  <= 3'd1;
              descendo <= 1'b0;
            end else begin
              posicao <= posicao - 3'd1;
            end
          end
        end

        PARADO: begin
          contagem <= '0;
          if (ligar) estado <= ESPERA;
        end

        default: begin
          estado   <= INICIAL;
          contagem <= '0;
        end
      endcase
    end
  end

endmodule
